wdf_pool: RTL



---
 rtl/wdf_pool.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wdf_pool.sv
// wdf_pool: pointer-addressed write-data buffer pool with one allocator, one write port,
// two read/release ports. Define WDF_POOL_PARITY_CHK_EN to enable pointer parity checking.
module wdf_pool #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [PTR_W-1:0]     alloc_ptr,
  input  logic                 wr,
  input  logic [PTR_W-1:0]     wr_ptr,
  input  logic                 wr_p,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd0,
  input  logic [PTR_W-1:0]     rd0_ptr,
  input  logic                 rd0_p,
  input  logic                 rd0_rel,
  output logic                 rd0_vld,
  output logic [DATA_W-1:0]    rd0_data,
  input  logic                 rd1,
  input  logic [PTR_W-1:0]     rd1_ptr,
  input  logic                 rd1_p,
  input  logic                 rd1_rel,
  output logic                 rd1_vld,
  output logic [DATA_W-1:0]    rd1_data,
  output logic [PTR_W:0]       credits,
  output logic                 err,
  output logic                 perr,
  output logic [2*DEPTH-1:0]   slot_state_dbg
);

  // Handshake: alloc_req/alloc_gnt complete in the same cycle (no holding); wr/rdN are
  // single-cycle strobes with no backpressure; rdN_vld is a one-cycle pulse one edge later.

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ALLOC = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_t;

  slot_t             state_q [DEPTH];
  slot_t             state_d [DEPTH];
  logic [DATA_W-1:0] mem     [DEPTH];

  logic             wr_par_ok, rd0_par_ok, rd1_par_ok;
  logic             wr_ok, rd0_ok, rd1_ok;
  logic             rd0_rel_ok, rd1_rel_ok;
  logic             err_set, perr_set;
  logic [PTR_W-1:0] free_idx;
  logic [PTR_W:0]   rel_cnt;
  logic [PTR_W:0]   credits_d;

`ifdef WDF_POOL_PARITY_CHK_EN
  assign wr_par_ok  = ~^{wr_ptr, wr_p};
  assign rd0_par_ok = ~^{rd0_ptr, rd0_p};
  assign rd1_par_ok = ~^{rd1_ptr, rd1_p};
`else
  logic unused_par;
  assign unused_par = ^{wr_p, rd0_p, rd1_p};
  assign wr_par_ok  = 1'b1;
  assign rd0_par_ok = 1'b1;
  assign rd1_par_ok = 1'b1;
`endif

  assign wr_ok  = wr  && wr_par_ok  && (state_q[wr_ptr]  != SLOT_FREE);
  assign rd0_ok = rd0 && rd0_par_ok && (state_q[rd0_ptr] == SLOT_FULL);
  assign rd1_ok = rd1 && rd1_par_ok && (state_q[rd1_ptr] == SLOT_FULL);
  assign rd0_rel_ok = rd0_ok && rd0_rel;
  assign rd1_rel_ok = rd1_ok && rd1_rel;

  assign err_set  = (wr  && wr_par_ok  && (state_q[wr_ptr]  == SLOT_FREE)) ||
                    (rd0 && rd0_par_ok && (state_q[rd0_ptr] != SLOT_FULL)) ||
                    (rd1 && rd1_par_ok && (state_q[rd1_ptr] != SLOT_FULL));
  assign perr_set = (wr && !wr_par_ok) || (rd0 && !rd0_par_ok) || (rd1 && !rd1_par_ok);

  // Both ports releasing the same slot frees it only once.
  assign rel_cnt = (PTR_W+1)'(rd0_rel_ok) +
                   (PTR_W+1)'(rd1_rel_ok && !(rd0_rel_ok && (rd0_ptr == rd1_ptr)));

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) free_idx = PTR_W'(i);
    end
  end

  assign alloc_gnt = alloc_req && (credits != '0);
  assign alloc_ptr = alloc_gnt ? free_idx : '0;
  assign credits_d = credits - (PTR_W+1)'(alloc_gnt) + rel_cnt;

  // Release is applied last so it beats a same-cycle write to the same slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      if (alloc_gnt && (alloc_ptr == PTR_W'(i))) state_d[i] = SLOT_ALLOC;
      if (wr_ok && (wr_ptr == PTR_W'(i)))        state_d[i] = SLOT_FULL;
      if ((rd0_rel_ok && (rd0_ptr == PTR_W'(i))) ||
          (rd1_rel_ok && (rd1_ptr == PTR_W'(i)))) state_d[i] = SLOT_FREE;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_state_dbg[2*i +: 2] = state_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_FREE;
      credits  <= (PTR_W+1)'(DEPTH);
      rd0_vld  <= 1'b0;
      rd1_vld  <= 1'b0;
      rd0_data <= '0;
      rd1_data <= '0;
      err      <= 1'b0;
      perr     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      credits <= credits_d;
      rd0_vld <= rd0_ok;
      rd1_vld <= rd1_ok;
      if (rd0_ok) rd0_data <= mem[rd0_ptr];
      if (rd1_ok) rd1_data <= mem[rd1_ptr];
      if (err_set)  err  <= 1'b1;
      if (perr_set) perr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule
